alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
ALU reservation station. It receives a dispatched instruction together with the operand data/tag pairs read from the register file. Entries wait, snooping the ALU and LS write-back buses, until both operands are ready. The oldest-index ready entry is then issued to the ALU. It sits between the dispatcher/register file and the ALU, as the consumer of register-file read ports and write-back broadcasts.

Parameters:
RS_SIZE, 8, number of entries (power of two, 2..16)
DATA_W, 32, operand/data width
TAG_W, 4, rename tag width
TAG_FREE, 4'b0000, tag value meaning "operand holds valid data"
OP_W, 6, decoded ALU opcode width
ADDR_W, 32, instruction address width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
disp_en  in  1  dispatch request this cycle
disp_op  in  OP_W  opcode
disp_dest_tag  in  TAG_W  rename tag of the result
disp_data_o  in  DATA_W  operand 1 data from register file
disp_tag_o  in  TAG_W  operand 1 tag from register file
disp_data_t  in  DATA_W  operand 2 data from register file
disp_tag_t  in  TAG_W  operand 2 tag from register file
disp_imm  in  DATA_W  immediate
disp_pc  in  ADDR_W  instruction pc
alu_wb_en  in  1  ALU write-back broadcast valid
alu_wb_tag  in  TAG_W  ALU broadcast tag
alu_wb_data  in  DATA_W  ALU broadcast data
ls_wb_en  in  1  LS write-back broadcast valid
ls_wb_tag  in  TAG_W  LS broadcast tag
ls_wb_data  in  DATA_W  LS broadcast data
rs_full  out  1  all entries busy (combinational from busy vector)
ex_valid  out  1  issue valid to ALU (registered)
ex_op  out  OP_W  issued opcode
ex_data_o  out  DATA_W  issued operand 1
ex_data_t  out  DATA_W  issued operand 2
ex_imm  out  DATA_W  issued immediate
ex_pc  out  ADDR_W  issued pc
ex_dest_tag  out  TAG_W  issued destination tag

Behaviour:
- Entry state: busy, op, Qo/Qt tags, Vo/Vt data, imm, pc, dest. An operand is ready when its Q equals TAG_FREE.
- Reset: all busy cleared. ex_valid=0. All ex_* data outputs are 0. rs_full=0. Reset mid-operation discards every entry and any pending issue.
- Dispatch: on the edge where disp_en=1 and rs_full=0, the instruction is written into the lowest-index non-busy entry. disp_en while rs_full=1 is dropped with no state change. The dispatcher is responsible for stalling.
- Dispatch-time forwarding: if disp_tag_x != TAG_FREE and matches an enabled broadcast tag in the same cycle, the entry stores the broadcast data with Q=TAG_FREE.
- Snoop: every busy entry whose Qx equals an enabled broadcast tag latches that broadcast's data and sets Qx=TAG_FREE at the edge.
- Broadcasts carrying TAG_FREE are ignored. If ALU and LS carry the same tag, ALU data wins (illegal in practice).
- Issue select uses state at the start of the cycle: the lowest-index busy entry with both operands ready.
  - If one exists, at the edge: ex_* are loaded from it, ex_valid=1, and the entry's busy is cleared.
  - Otherwise ex_valid=0 at that edge.
  - One issue per cycle. The ALU is always accepting, so there is no back-pressure.
- Latency (base build):
  - Dispatch with both operands ready at edge t: ex_valid is high in the cycle after edge t+1.
  - Operand woken by a broadcast at edge t: issue is loaded at edge t+1 at the earliest.
- An entry freed at edge t is not allocatable by a dispatch at the same edge t. rs_full reflects busy after edge t.
- Simultaneous dispatch, snoop and issue on different entries all take effect at the same edge.

Optional Feature:
RS_WAKEUP_BYPASS_EN
- Defined: an entry whose remaining non-ready operand(s) match an enabled broadcast in the current cycle counts as ready for issue select. It is issued at that same edge, with the operand data taken directly from the broadcast. This removes one cycle of wakeup latency.
- Priority is unchanged: lowest index among ready-or-bypass-ready entries.
- Dispatch-time forwarding still only writes the entry. There is no dispatch-to-issue bypass in the same cycle.
- Undefined: behaviour is exactly as described above.

Test Plan:
- Reset, then dispatch op=1, tag_o=tag_t=0, data_o=5, data_t=7, dest=3 -> ex_valid=1 two edges after dispatch with ex_data_o=5, ex_data_t=7, ex_dest_tag=3; ex_valid=0 on the next cycle.
- Dispatch with tag_o=4 (pending), then alu_wb_en=1 tag 4 data 0x1234 -> ex_data_o=0x1234 issued at the edge after the broadcast edge (the same edge with RS_WAKEUP_BYPASS_EN).
- Dispatch with tag_t=6 while ls_wb_en=1 tag 6 data 0xBEEF in the same cycle -> entry ready immediately, issued with ex_data_t=0xBEEF next edge.
- Fill all 8 entries with pending tag 9 -> rs_full=1. A 9th disp_en is dropped. Broadcast tag 9 -> entries issue in index order 0..7, one per cycle, and rs_full drops after the first issue.
- Entries 2 and 5 become ready in the same cycle -> entry 2 is issued first, entry 5 on the next edge.
- Assert rst with 3 busy entries and ex_valid=1 -> next cycle ex_valid=0, rs_full=0, and no stale entry ever issues afterwards.

Source files
------------

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ALU ops, snoops ALU/LS write-back, issues oldest-index ready entry.
// Optional build macro RS_WAKEUP_BYPASS_EN lets an entry issue on the same edge its last operand is broadcast.
module alu_rs #(
    parameter int               RS_SIZE  = 8,
    parameter int               DATA_W   = 32,
    parameter int               TAG_W    = 4,
    parameter logic [TAG_W-1:0] TAG_FREE = '0,
    parameter int               OP_W     = 6,
    parameter int               ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_en,
    input  logic [OP_W-1:0]   disp_op,
    input  logic [TAG_W-1:0]  disp_dest_tag,
    input  logic [DATA_W-1:0] disp_data_o,
    input  logic [TAG_W-1:0]  disp_tag_o,
    input  logic [DATA_W-1:0] disp_data_t,
    input  logic [TAG_W-1:0]  disp_tag_t,
    input  logic [DATA_W-1:0] disp_imm,
    input  logic [ADDR_W-1:0] disp_pc,
    input  logic              alu_wb_en,
    input  logic [TAG_W-1:0]  alu_wb_tag,
    input  logic [DATA_W-1:0] alu_wb_data,
    input  logic              ls_wb_en,
    input  logic [TAG_W-1:0]  ls_wb_tag,
    input  logic [DATA_W-1:0] ls_wb_data,
    output logic              rs_full,
    output logic              ex_valid,
    output logic [OP_W-1:0]   ex_op,
    output logic [DATA_W-1:0] ex_data_o,
    output logic [DATA_W-1:0] ex_data_t,
    output logic [DATA_W-1:0] ex_imm,
    output logic [ADDR_W-1:0] ex_pc,
    output logic [TAG_W-1:0]  ex_dest_tag
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // A broadcast carrying TAG_FREE never matches anything.
    function automatic logic tag_hit(input logic en, input logic [TAG_W-1:0] bc_tag,
                                     input logic [TAG_W-1:0] tag);
        return en && (bc_tag == tag) && (tag != TAG_FREE);
    endfunction

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [OP_W-1:0]    op_q   [RS_SIZE];
    logic [OP_W-1:0]    op_d   [RS_SIZE];
    logic [TAG_W-1:0]   qo_q   [RS_SIZE];
    logic [TAG_W-1:0]   qo_d   [RS_SIZE];
    logic [TAG_W-1:0]   qt_q   [RS_SIZE];
    logic [TAG_W-1:0]   qt_d   [RS_SIZE];
    logic [DATA_W-1:0]  vo_q   [RS_SIZE];
    logic [DATA_W-1:0]  vo_d   [RS_SIZE];
    logic [DATA_W-1:0]  vt_q   [RS_SIZE];
    logic [DATA_W-1:0]  vt_d   [RS_SIZE];
    logic [DATA_W-1:0]  imm_q  [RS_SIZE];
    logic [DATA_W-1:0]  imm_d  [RS_SIZE];
    logic [ADDR_W-1:0]  pc_q   [RS_SIZE];
    logic [ADDR_W-1:0]  pc_d   [RS_SIZE];
    logic [TAG_W-1:0]   dest_q [RS_SIZE];
    logic [TAG_W-1:0]   dest_d [RS_SIZE];

    logic [RS_SIZE-1:0] hit_o, hit_t, rdy;
    logic [DATA_W-1:0]  nvo [RS_SIZE];
    logic [DATA_W-1:0]  nvt [RS_SIZE];

    logic              alloc_vld, iss_vld;
    logic [IDX_W-1:0]  alloc_idx, iss_idx;
    logic              dh_o_alu, dh_o_ls, dh_t_alu, dh_t_ls;

    logic              ex_valid_q;
    logic [OP_W-1:0]   ex_op_q;
    logic [DATA_W-1:0] ex_data_o_q, ex_data_t_q, ex_imm_q;
    logic [ADDR_W-1:0] ex_pc_q;
    logic [TAG_W-1:0]  ex_dest_q;

    assign rs_full = &busy_q;

    // Per-entry wakeup: nvo/nvt is the operand value after this cycle's broadcasts (ALU beats LS).
    always_comb begin
        hit_o = '0;
        hit_t = '0;
        rdy   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            hit_o[i] = tag_hit(alu_wb_en, alu_wb_tag, qo_q[i]) || tag_hit(ls_wb_en, ls_wb_tag, qo_q[i]);
            hit_t[i] = tag_hit(alu_wb_en, alu_wb_tag, qt_q[i]) || tag_hit(ls_wb_en, ls_wb_tag, qt_q[i]);
            nvo[i]   = !hit_o[i] ? vo_q[i] :
                       tag_hit(alu_wb_en, alu_wb_tag, qo_q[i]) ? alu_wb_data : ls_wb_data;
            nvt[i]   = !hit_t[i] ? vt_q[i] :
                       tag_hit(alu_wb_en, alu_wb_tag, qt_q[i]) ? alu_wb_data : ls_wb_data;
`ifdef RS_WAKEUP_BYPASS_EN
            rdy[i]   = busy_q[i] && ((qo_q[i] == TAG_FREE) || hit_o[i])
                                 && ((qt_q[i] == TAG_FREE) || hit_t[i]);
`else
            rdy[i]   = busy_q[i] && (qo_q[i] == TAG_FREE) && (qt_q[i] == TAG_FREE);
`endif
        end
    end

    // Lowest-index selection for both issue and allocation, from start-of-cycle busy.
    always_comb begin
        iss_vld   = 1'b0;
        iss_idx   = '0;
        alloc_vld = 1'b0;
        alloc_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (rdy[i]) begin
                iss_vld = 1'b1;
                iss_idx = IDX_W'(i);
            end
            if (!busy_q[i]) begin
                alloc_vld = disp_en;
                alloc_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        dh_o_alu = tag_hit(alu_wb_en, alu_wb_tag, disp_tag_o);
        dh_o_ls  = tag_hit(ls_wb_en, ls_wb_tag, disp_tag_o);
        dh_t_alu = tag_hit(alu_wb_en, alu_wb_tag, disp_tag_t);
        dh_t_ls  = tag_hit(ls_wb_en, ls_wb_tag, disp_tag_t);
        busy_d   = busy_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            op_d[i]   = op_q[i];
            imm_d[i]  = imm_q[i];
            pc_d[i]   = pc_q[i];
            dest_d[i] = dest_q[i];
            qo_d[i]   = (busy_q[i] && hit_o[i]) ? TAG_FREE : qo_q[i];
            qt_d[i]   = (busy_q[i] && hit_t[i]) ? TAG_FREE : qt_q[i];
            vo_d[i]   = busy_q[i] ? nvo[i] : vo_q[i];
            vt_d[i]   = busy_q[i] ? nvt[i] : vt_q[i];
        end
        if (iss_vld) begin
            busy_d[iss_idx] = 1'b0;
        end
        // The allocated slot was idle at cycle start, so it never collides with the issued slot.
        if (alloc_vld) begin
            busy_d[alloc_idx] = 1'b1;
            op_d[alloc_idx]   = disp_op;
            imm_d[alloc_idx]  = disp_imm;
            pc_d[alloc_idx]   = disp_pc;
            dest_d[alloc_idx] = disp_dest_tag;
            qo_d[alloc_idx]   = (dh_o_alu || dh_o_ls) ? TAG_FREE : disp_tag_o;
            qt_d[alloc_idx]   = (dh_t_alu || dh_t_ls) ? TAG_FREE : disp_tag_t;
            vo_d[alloc_idx]   = dh_o_alu ? alu_wb_data : dh_o_ls ? ls_wb_data : disp_data_o;
            vt_d[alloc_idx]   = dh_t_alu ? alu_wb_data : dh_t_ls ? ls_wb_data : disp_data_t;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            ex_valid_q  <= 1'b0;
            ex_op_q     <= '0;
            ex_data_o_q <= '0;
            ex_data_t_q <= '0;
            ex_imm_q    <= '0;
            ex_pc_q     <= '0;
            ex_dest_q   <= '0;
        end else begin
            busy_q     <= busy_d;
            ex_valid_q <= iss_vld;
            if (iss_vld) begin
                ex_op_q     <= op_q[iss_idx];
                ex_data_o_q <= nvo[iss_idx];
                ex_data_t_q <= nvt[iss_idx];
                ex_imm_q    <= imm_q[iss_idx];
                ex_pc_q     <= pc_q[iss_idx];
                ex_dest_q   <= dest_q[iss_idx];
            end
        end
    end

    // Entry payload is qualified by busy, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            op_q[i]   <= op_d[i];
            qo_q[i]   <= qo_d[i];
            qt_q[i]   <= qt_d[i];
            vo_q[i]   <= vo_d[i];
            vt_q[i]   <= vt_d[i];
            imm_q[i]  <= imm_d[i];
            pc_q[i]   <= pc_d[i];
            dest_q[i] <= dest_d[i];
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_op       = ex_op_q;
    assign ex_data_o   = ex_data_o_q;
    assign ex_data_t   = ex_data_t_q;
    assign ex_imm      = ex_imm_q;
    assign ex_pc       = ex_pc_q;
    assign ex_dest_tag = ex_dest_q;

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: expected issues are queued at dispatch and popped when ex_valid is seen.
module tb_alu_rs;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int OP_W   = 6;
    localparam int ADDR_W = 32;
`ifdef RS_WAKEUP_BYPASS_EN
    localparam int WAKE_LAT = 0;
`else
    localparam int WAKE_LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              disp_en;
    logic [OP_W-1:0]   disp_op;
    logic [TAG_W-1:0]  disp_dest_tag, disp_tag_o, disp_tag_t;
    logic [DATA_W-1:0] disp_data_o, disp_data_t, disp_imm;
    logic [ADDR_W-1:0] disp_pc;
    logic              alu_wb_en, ls_wb_en;
    logic [TAG_W-1:0]  alu_wb_tag, ls_wb_tag;
    logic [DATA_W-1:0] alu_wb_data, ls_wb_data;
    logic              rs_full, ex_valid;
    logic [OP_W-1:0]   ex_op;
    logic [DATA_W-1:0] ex_data_o, ex_data_t, ex_imm;
    logic [ADDR_W-1:0] ex_pc;
    logic [TAG_W-1:0]  ex_dest_tag;

    alu_rs #(.RS_SIZE(8), .DATA_W(DATA_W), .TAG_W(TAG_W), .TAG_FREE(4'b0000),
             .OP_W(OP_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .disp_en(disp_en), .disp_op(disp_op),
        .disp_dest_tag(disp_dest_tag), .disp_data_o(disp_data_o), .disp_tag_o(disp_tag_o),
        .disp_data_t(disp_data_t), .disp_tag_t(disp_tag_t), .disp_imm(disp_imm),
        .disp_pc(disp_pc), .alu_wb_en(alu_wb_en), .alu_wb_tag(alu_wb_tag),
        .alu_wb_data(alu_wb_data), .ls_wb_en(ls_wb_en), .ls_wb_tag(ls_wb_tag),
        .ls_wb_data(ls_wb_data), .rs_full(rs_full), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_data_o(ex_data_o), .ex_data_t(ex_data_t), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_dest_tag(ex_dest_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] pc;
        logic [TAG_W-1:0]  dest;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a,
                                input logic [DATA_W-1:0] b, input logic [TAG_W-1:0] dest);
        exp_t e;
        e.op   = op;
        e.a    = a;
        e.b    = b;
        e.imm  = 32'h1000_0000 | 32'(dest);
        e.pc   = 32'h0000_4000 + (32'(dest) << 2);
        e.dest = dest;
        return e;
    endfunction

    task automatic drive_disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tg_o,
                              input logic [DATA_W-1:0] d_o, input logic [TAG_W-1:0] tg_t,
                              input logic [DATA_W-1:0] d_t, input logic [TAG_W-1:0] dest);
        disp_en       = 1'b1;
        disp_op       = op;
        disp_tag_o    = tg_o;
        disp_data_o   = d_o;
        disp_tag_t    = tg_t;
        disp_data_t   = d_t;
        disp_dest_tag = dest;
        disp_imm      = 32'h1000_0000 | 32'(dest);
        disp_pc       = 32'h0000_4000 + (32'(dest) << 2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
        total++;
        if (rs_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", rs_full); end
        total++;
        if ({ex_op, ex_data_o, ex_data_t, ex_imm, ex_pc, ex_dest_tag} !== '0) begin
            bad++; $display("FAIL reset_data: got a=%h b=%h dest=%0d want zeros", ex_data_o, ex_data_t, ex_dest_tag);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_idle: got %b want 0", ex_valid); end
    endtask

    task automatic test_basic();
        exp_t e;
        drive_disp(6'd1, 4'd0, 32'd5, 4'd0, 32'd7, 4'd3);
        sb.push_back(mk(6'd1, 32'd5, 32'd7, 4'd3));
        @(negedge clk);
        disp_en = 1'b0;
        total++;
        if (ex_valid !== 1'b0) begin bad++; $display("FAIL basic_early: got %b want 0", ex_valid); end
        @(negedge clk);
        total++;
        if (ex_valid !== 1'b1 || sb.size() == 0) begin
            bad++; $display("FAIL basic_issue: got valid=%b want 1", ex_valid);
        end else begin
            e = sb.pop_front();
            if ({ex_op, ex_data_o, ex_data_t, ex_imm, ex_pc, ex_dest_tag} !== {e.op, e.a, e.b, e.imm, e.pc, e.dest}) begin
                bad++; $display("FAIL basic_data: got op=%0d a=%h b=%h dest=%0d want op=%0d a=%h b=%h dest=%0d",
                                ex_op, ex_data_o, ex_data_t, ex_dest_tag, e.op, e.a, e.b, e.dest);
            end
        end
        @(negedge clk);
        total++;
        if (ex_valid !== 1'b0) begin bad++; $display("FAIL basic_after: got %b want 0", ex_valid); end
    endtask

    // ALU and LS broadcast the same tag; ALU data must be taken.
    task automatic test_wakeup();
        exp_t e;
        drive_disp(6'd2, 4'd4, 32'hDEAD, 4'd0, 32'h55, 4'd5);
        sb.push_back(mk(6'd2, 32'h1234, 32'h55, 4'd5));
        @(negedge clk);
        disp_en = 1'b0;
        @(negedge clk);
        total++;
        if (ex_valid !== 1'b0) begin bad++; $display("FAIL wake_pending: got %b want 0", ex_valid); end
        alu_wb_en = 1'b1; alu_wb_tag = 4'd4; alu_wb_data = 32'h1234;
        ls_wb_en  = 1'b1; ls_wb_tag  = 4'd4; ls_wb_data  = 32'h9999;
        @(negedge clk);
        alu_wb_en = 1'b0;
        ls_wb_en  = 1'b0;
        for (int k = 0; k < WAKE_LAT; k++) begin
            total++;
            if (ex_valid !== 1'b0) begin bad++; $display("FAIL wake_early: got %b want 0", ex_valid); end
            @(negedge clk);
        end
        total++;
        if (ex_valid !== 1'b1 || sb.size() == 0) begin
            bad++; $display("FAIL wake_issue: got valid=%b want 1", ex_valid);
        end else begin
            e = sb.pop_front();
            if ({ex_op, ex_data_o, ex_data_t, ex_imm, ex_pc, ex_dest_tag} !== {e.op, e.a, e.b, e.imm, e.pc, e.dest}) begin
                bad++; $display("FAIL wake_data: got a=%h b=%h dest=%0d want a=%h b=%h dest=%0d",
                                ex_data_o, ex_data_t, ex_dest_tag, e.a, e.b, e.dest);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_disp_forward();
        exp_t e;
        drive_disp(6'd3, 4'd0, 32'h11, 4'd6, 32'h0, 4'd6);
        ls_wb_en = 1'b1; ls_wb_tag = 4'd6; ls_wb_data = 32'hBEEF;
        sb.push_back(mk(6'd3, 32'h11, 32'hBEEF, 4'd6));
        @(negedge clk);
        disp_en  = 1'b0;
        ls_wb_en = 1'b0;
        total++;
        if (ex_valid !== 1'b0) begin bad++; $display("FAIL fwd_early: got %b want 0", ex_valid); end
        @(negedge clk);
        total++;
        if (ex_valid !== 1'b1 || sb.size() == 0) begin
            bad++; $display("FAIL fwd_issue: got valid=%b want 1", ex_valid);
        end else begin
            e = sb.pop_front();
            if ({ex_op, ex_data_o, ex_data_t, ex_imm, ex_pc, ex_dest_tag} !== {e.op, e.a, e.b, e.imm, e.pc, e.dest}) begin
                bad++; $display("FAIL fwd_data: got a=%h b=%h dest=%0d want a=%h b=%h dest=%0d",
                                ex_data_o, ex_data_t, ex_dest_tag, e.a, e.b, e.dest);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_fill();
        exp_t e;
        int   n;
        for (int k = 0; k < 8; k++) begin
            drive_disp(6'd4, 4'd9, 32'h0, 4'd0, 32'h100 + 32'(k), 4'(k));
            sb.push_back(mk(6'd4, 32'hAAAA, 32'h100 + 32'(k), 4'(k)));
            @(negedge clk);
            if (k == 6) begin
                total++;
                if (rs_full !== 1'b0) begin bad++; $display("FAIL fill_seven: got %b want 0", rs_full); end
            end
        end
        total++;
        if (rs_full !== 1'b1) begin bad++; $display("FAIL fill_full: got %b want 1", rs_full); end
        drive_disp(6'd5, 4'd0, 32'h77, 4'd0, 32'h77, 4'd15);
        @(negedge clk);
        disp_en = 1'b0;
        total++;
        if (rs_full !== 1'b1 || ex_valid !== 1'b0) begin
            bad++; $display("FAIL fill_drop: got full=%b valid=%b want full=1 valid=0", rs_full, ex_valid);
        end
        alu_wb_en = 1'b1; alu_wb_tag = 4'd9; alu_wb_data = 32'hAAAA;
        @(negedge clk);
        alu_wb_en = 1'b0;
        n = 0;
        for (int c = 0; c < 14; c++) begin
            if (ex_valid === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL fill_extra: got dest=%0d want no issue", ex_dest_tag);
                end else begin
                    e = sb.pop_front();
                    if ({ex_op, ex_data_o, ex_data_t, ex_imm, ex_pc, ex_dest_tag} !== {e.op, e.a, e.b, e.imm, e.pc, e.dest}) begin
                        bad++; $display("FAIL fill_order: got dest=%0d a=%h b=%h want dest=%0d a=%h b=%h",
                                        ex_dest_tag, ex_data_o, ex_data_t, e.dest, e.a, e.b);
                    end
                end
                n++;
                if (n == 1) begin
                    total++;
                    if (rs_full !== 1'b0) begin bad++; $display("FAIL fill_unfull: got %b want 0", rs_full); end
                end
            end else if (n > 0 && n < 8) begin
                total++; bad++;
                $display("FAIL fill_gap: got idle after %0d issues want back-to-back", n);
            end
            @(negedge clk);
        end
        total++;
        if (n != 8) begin bad++; $display("FAIL fill_count: got %0d want 8", n); end
    endtask

    // Entries 2 and 5 wake together (tag 11); 0,1,3,4 (tag 10) are released afterwards via LS.
    task automatic test_priority();
        exp_t e;
        int   n;
        for (int k = 0; k < 6; k++) begin
            drive_disp(6'd7, (k == 2 || k == 5) ? 4'd11 : 4'd10, 32'h0, 4'd0, 32'h200 + 32'(k), 4'(8 + k));
            @(negedge clk);
        end
        disp_en = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (p == 0) begin
                sb.push_back(mk(6'd7, 32'hB0B0, 32'h202, 4'd10));
                sb.push_back(mk(6'd7, 32'hB0B0, 32'h205, 4'd13));
                alu_wb_en = 1'b1; alu_wb_tag = 4'd11; alu_wb_data = 32'hB0B0;
            end else begin
                sb.push_back(mk(6'd7, 32'hA0A0, 32'h200, 4'd8));
                sb.push_back(mk(6'd7, 32'hA0A0, 32'h201, 4'd9));
                sb.push_back(mk(6'd7, 32'hA0A0, 32'h203, 4'd11));
                sb.push_back(mk(6'd7, 32'hA0A0, 32'h204, 4'd12));
                ls_wb_en = 1'b1; ls_wb_tag = 4'd10; ls_wb_data = 32'hA0A0;
            end
            @(negedge clk);
            alu_wb_en = 1'b0;
            ls_wb_en  = 1'b0;
            n = 0;
            for (int c = 0; c < 8; c++) begin
                if (ex_valid === 1'b1) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++; $display("FAIL prio_extra: got dest=%0d want no issue", ex_dest_tag);
                    end else begin
                        e = sb.pop_front();
                        if ({ex_op, ex_data_o, ex_data_t, ex_imm, ex_pc, ex_dest_tag} !== {e.op, e.a, e.b, e.imm, e.pc, e.dest}) begin
                            bad++; $display("FAIL prio_order: got dest=%0d a=%h b=%h want dest=%0d a=%h b=%h",
                                            ex_dest_tag, ex_data_o, ex_data_t, e.dest, e.a, e.b);
                        end
                    end
                    n++;
                end else if (n > 0 && n < (p == 0 ? 2 : 4)) begin
                    total++; bad++;
                    $display("FAIL prio_gap: got idle after %0d issues want back-to-back", n);
                end
                @(negedge clk);
            end
            total++;
            if (n != (p == 0 ? 2 : 4)) begin
                bad++; $display("FAIL prio_count: phase %0d got %0d want %0d", p, n, (p == 0 ? 2 : 4));
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   stale;
        for (int k = 0; k < 3; k++) begin
            drive_disp(6'd9, 4'd13, 32'h0, 4'd13, 32'h0, 4'(1 + k));
            @(negedge clk);
        end
        drive_disp(6'd10, 4'd0, 32'h3C, 4'd0, 32'h4D, 4'd4);
        sb.push_back(mk(6'd10, 32'h3C, 32'h4D, 4'd4));
        @(negedge clk);
        disp_en = 1'b0;
        @(negedge clk);
        total++;
        if (ex_valid !== 1'b1 || sb.size() == 0) begin
            bad++; $display("FAIL rmid_issue: got valid=%b want 1", ex_valid);
        end else begin
            e = sb.pop_front();
            if ({ex_op, ex_data_o, ex_data_t, ex_imm, ex_pc, ex_dest_tag} !== {e.op, e.a, e.b, e.imm, e.pc, e.dest}) begin
                bad++; $display("FAIL rmid_data: got a=%h b=%h dest=%0d want a=%h b=%h dest=%0d",
                                ex_data_o, ex_data_t, ex_dest_tag, e.a, e.b, e.dest);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (ex_valid !== 1'b0 || rs_full !== 1'b0 || ex_data_o !== '0 || ex_dest_tag !== '0) begin
            bad++; $display("FAIL rmid_clear: got valid=%b full=%b a=%h dest=%0d want 0 0 0 0",
                            ex_valid, rs_full, ex_data_o, ex_dest_tag);
        end
        alu_wb_en = 1'b1; alu_wb_tag = 4'd13; alu_wb_data = 32'h5A5A;
        @(negedge clk);
        alu_wb_en = 1'b0;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            if (ex_valid !== 1'b0) stale++;
            @(negedge clk);
        end
        total++;
        if (stale != 0) begin bad++; $display("FAIL rmid_stale: got %0d stale issues want 0", stale); end
    endtask

    initial begin
        rst = 1'b1; disp_en = 1'b0; disp_op = '0; disp_dest_tag = '0;
        disp_data_o = '0; disp_tag_o = '0; disp_data_t = '0; disp_tag_t = '0;
        disp_imm = '0; disp_pc = '0;
        alu_wb_en = 1'b0; alu_wb_tag = '0; alu_wb_data = '0;
        ls_wb_en = 1'b0; ls_wb_tag = '0; ls_wb_data = '0;
        test_reset();
        test_basic();
        test_wakeup();
        test_disp_forward();
        test_fill();
        test_priority();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_left: got %0d pending want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
